// File: rtl/rx_frame_capture.sv
// Video capture front end: crops an active window from sync-framed VIDEO and packs
// reduced-depth pixels into BRAM words, with optional double buffering and sync lock.
module rx_frame_capture #(
    parameter int H_START     = 0,
    parameter int H_ACTIVE    = 576,
    parameter int V_START     = 0,
    parameter int V_ACTIVE    = 384,
    parameter int PIX_IN_W    = 10,
    parameter int PIX_OUT_W   = 8,
    parameter int PACK        = 1,
    parameter int ADDR_W      = 14,
    parameter int DOUBLE_BUF  = 0,
    parameter bit HS_POL      = 1'b0,
    parameter bit VS_POL      = 1'b0,
    parameter int LOCK_FRAMES = 4,
    parameter int CNT_W       = 11
) (
    input  logic                      O_CLK,
    input  logic                      RST,
    input  logic                      ENABLE,
    input  logic                      O_HS,
    input  logic                      O_VS,
    input  logic [PIX_IN_W-1:0]       VIDEO,
    output logic [PIX_OUT_W*PACK-1:0] BRAM_DIN,
    output logic [ADDR_W-1:0]         BRAM_ADDR,
    output logic                      BRAM_WE,
    output logic                      WR_BANK,
    output logic                      RD_BANK,
    output logic                      FRAME_DONE,
    output logic                      LOCKED,
    output logic [CNT_W-1:0]          LINE_COUNT
);

    localparam int LANE_W  = (PACK > 1) ? $clog2(PACK) : 1;
    localparam int WORD_W  = PIX_OUT_W * PACK;
    localparam int IDX_W   = ADDR_W + 1;
    localparam int BANK_AW = ADDR_W - DOUBLE_BUF;
    localparam int STB_W   = $clog2(LOCK_FRAMES + 1);

    localparam logic [CNT_W:0]      H_BEG     = (CNT_W+1)'(H_START);
    localparam logic [CNT_W:0]      H_END     = (CNT_W+1)'(H_START + H_ACTIVE);
    localparam logic [CNT_W:0]      V_BEG     = (CNT_W+1)'(V_START);
    localparam logic [CNT_W:0]      V_END     = (CNT_W+1)'(V_START + V_ACTIVE);
    localparam logic [CNT_W-1:0]    CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [IDX_W-1:0]    BANK_CAP  = {{(IDX_W-1){1'b0}}, 1'b1} << BANK_AW;
    localparam logic [LANE_W-1:0]   LANE_LAST = LANE_W'(PACK - 1);
    localparam logic [STB_W-1:0]    LOCK_N    = STB_W'(LOCK_FRAMES);

    logic                 hs_r;
    logic                 vs_r;
    logic                 hs_d_r;
    logic                 vs_d_r;
    logic [PIX_IN_W-1:0]  video_r;

    logic [CNT_W-1:0]     x_r;
    logic [CNT_W-1:0]     y_r;

    logic                 cap_en_r;
    logic [IDX_W-1:0]     idx_r;
    logic [LANE_W-1:0]    lane_r;
    logic [WORD_W-1:0]    pack_r;
    logic                 we_r;
    logic [WORD_W-1:0]    din_r;
    logic [ADDR_W-1:0]    addr_r;

    logic                 frame_done_r;
    logic                 wr_bank_r;
    logic                 rd_bank_r;
    logic [CNT_W-1:0]     line_count_r;
    logic [STB_W-1:0]     stable_r;
    logic                 locked_r;

    logic                 hs_edge_s;
    logic                 vs_edge_s;
    logic                 visible_s;
    logic                 room_s;
    logic                 frame_ok_s;
    logic [PIX_OUT_W-1:0] pixel_s;
    logic [WORD_W-1:0]    word_s;
    logic [ADDR_W-1:0]    addr_s;
    logic [STB_W-1:0]     stable_next_s;
    logic                 unused_video_s;

    // Register sync and pixel together so edges and data stay aligned
    always_ff @(posedge O_CLK or posedge RST) begin
        if (RST) begin
            hs_r    <= 1'b0;
            vs_r    <= 1'b0;
            hs_d_r  <= 1'b0;
            vs_d_r  <= 1'b0;
            video_r <= '0;
        end else begin
            hs_r    <= O_HS;
            vs_r    <= O_VS;
            hs_d_r  <= hs_r;
            vs_d_r  <= vs_r;
            video_r <= VIDEO;
        end
    end

    // An edge is a registered transition into the active level
    assign hs_edge_s = (hs_r == HS_POL) && (hs_d_r != HS_POL);
    assign vs_edge_s = (vs_r == VS_POL) && (vs_d_r != VS_POL);

    assign visible_s = cap_en_r
                     && ({1'b0, x_r} >= H_BEG) && ({1'b0, x_r} < H_END)
                     && ({1'b0, y_r} >= V_BEG) && ({1'b0, y_r} < V_END);
    assign pixel_s        = video_r[PIX_IN_W-1 -: PIX_OUT_W];
    assign room_s         = (idx_r < BANK_CAP);
    assign frame_ok_s     = cap_en_r && ({1'b0, y_r} >= V_END);
    assign unused_video_s = ^video_r;

    // Position counters; a VS edge overrides a coincident HS edge for y
    always_ff @(posedge O_CLK or posedge RST) begin
        if (RST) begin
            x_r <= '0;
            y_r <= '0;
        end else begin
            if (hs_edge_s) begin
                x_r <= '0;
            end else if (x_r != CNT_MAX) begin
                x_r <= x_r + CNT_W'(1);
            end else begin
                x_r <= x_r;
            end

            if (vs_edge_s) begin
                y_r <= '0;
            end else if (hs_edge_s && (y_r != CNT_MAX)) begin
                y_r <= y_r + CNT_W'(1);
            end else begin
                y_r <= y_r;
            end
        end
    end

    // Insert the current pixel into its lane; lane 0 occupies the LSBs
    always_comb begin
        word_s = pack_r;
        for (int i = 0; i < PACK; i++) begin
            if (lane_r == LANE_W'(i)) begin
                word_s[i*PIX_OUT_W +: PIX_OUT_W] = pixel_s;
            end else begin
                word_s[i*PIX_OUT_W +: PIX_OUT_W] = pack_r[i*PIX_OUT_W +: PIX_OUT_W];
            end
        end
    end

    // With double buffering the address MSB names the bank being written
    always_comb begin
        if (DOUBLE_BUF != 0) begin
            addr_s = {wr_bank_r, idx_r[ADDR_W-2:0]};
        end else begin
            addr_s = idx_r[ADDR_W-1:0];
        end
    end

    // Packing and BRAM write path; writes stop once the bank is full
    always_ff @(posedge O_CLK or posedge RST) begin
        if (RST) begin
            cap_en_r <= 1'b0;
            idx_r    <= '0;
            lane_r   <= '0;
            pack_r   <= '0;
            we_r     <= 1'b0;
            din_r    <= '0;
            addr_r   <= '0;
        end else begin
            we_r <= 1'b0;
            if (vs_edge_s) begin
                cap_en_r <= ENABLE;
                idx_r    <= '0;
                lane_r   <= '0;
            end else if (hs_edge_s) begin
                lane_r <= '0;
            end else if (visible_s) begin
                pack_r <= word_s;
                if (lane_r == LANE_LAST) begin
                    lane_r <= '0;
                    if (room_s) begin
                        we_r   <= 1'b1;
                        din_r  <= word_s;
                        addr_r <= addr_s;
                        idx_r  <= idx_r + IDX_W'(1);
                    end
                end else begin
                    lane_r <= lane_r + LANE_W'(1);
                end
            end
        end
    end

    // A frame is stable when its line count repeats and y never saturated
    always_comb begin
        if ((y_r == line_count_r) && (y_r != CNT_MAX)) begin
            if (stable_r == LOCK_N) begin
                stable_next_s = stable_r;
            end else begin
                stable_next_s = stable_r + STB_W'(1);
            end
        end else begin
            stable_next_s = '0;
        end
    end

    // Frame completion, bank swap and lock tracking at each VS edge
    always_ff @(posedge O_CLK or posedge RST) begin
        if (RST) begin
            frame_done_r <= 1'b0;
            wr_bank_r    <= 1'b0;
            rd_bank_r    <= (DOUBLE_BUF != 0);
            line_count_r <= '0;
            stable_r     <= '0;
            locked_r     <= 1'b0;
        end else begin
            frame_done_r <= 1'b0;
            if (vs_edge_s) begin
                line_count_r <= y_r;
                stable_r     <= stable_next_s;
                locked_r     <= (stable_next_s == LOCK_N);
                if (frame_ok_s) begin
                    frame_done_r <= 1'b1;
                    rd_bank_r    <= wr_bank_r;
                    if (DOUBLE_BUF != 0) begin
                        wr_bank_r <= ~wr_bank_r;
                    end
                end
            end else if (y_r == CNT_MAX) begin
                stable_r <= '0;
                locked_r <= 1'b0;
            end
        end
    end

    assign BRAM_DIN   = din_r;
    assign BRAM_ADDR  = addr_r;
    assign BRAM_WE    = we_r;
    assign WR_BANK    = wr_bank_r;
    assign RD_BANK    = rd_bank_r;
    assign FRAME_DONE = frame_done_r;
    assign LOCKED     = locked_r;
    assign LINE_COUNT = line_count_r;

endmodule

// File: tb/tb_rx_frame_capture.sv
// Bench for rx_frame_capture: three parameterisations share one sync/video stream;
// a write scoreboard checks data, address and latency, a frame table checks status.
module tb_rx_frame_capture;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       enable;
    logic       hs;
    logic       vs;
    logic [9:0] video;

    logic [7:0]  a_din;  logic [5:0] a_addr; logic a_we, a_wrb, a_rdb, a_done, a_lock; logic [10:0] a_lc;
    logic [15:0] b_din;  logic [4:0] b_addr; logic b_we, b_wrb, b_rdb, b_done, b_lock; logic [10:0] b_lc;
    logic [7:0]  c_din;  logic [3:0] c_addr; logic c_we, c_wrb, c_rdb, c_done, c_lock; logic [10:0] c_lc;

    // A: PACK 1 single bank. B: PACK 2 double buffered. C: PACK 1 with a 16-word BRAM.
    rx_frame_capture #(.H_START(2), .H_ACTIVE(8), .V_START(1), .V_ACTIVE(4), .PACK(1),
                       .ADDR_W(6), .DOUBLE_BUF(0)) dut_a (
        .O_CLK(clk), .RST(rst), .ENABLE(enable), .O_HS(hs), .O_VS(vs), .VIDEO(video),
        .BRAM_DIN(a_din), .BRAM_ADDR(a_addr), .BRAM_WE(a_we), .WR_BANK(a_wrb), .RD_BANK(a_rdb),
        .FRAME_DONE(a_done), .LOCKED(a_lock), .LINE_COUNT(a_lc));
    rx_frame_capture #(.H_START(2), .H_ACTIVE(8), .V_START(1), .V_ACTIVE(4), .PACK(2),
                       .ADDR_W(5), .DOUBLE_BUF(1)) dut_b (
        .O_CLK(clk), .RST(rst), .ENABLE(enable), .O_HS(hs), .O_VS(vs), .VIDEO(video),
        .BRAM_DIN(b_din), .BRAM_ADDR(b_addr), .BRAM_WE(b_we), .WR_BANK(b_wrb), .RD_BANK(b_rdb),
        .FRAME_DONE(b_done), .LOCKED(b_lock), .LINE_COUNT(b_lc));
    rx_frame_capture #(.H_START(2), .H_ACTIVE(8), .V_START(1), .V_ACTIVE(4), .PACK(1),
                       .ADDR_W(4), .DOUBLE_BUF(0)) dut_c (
        .O_CLK(clk), .RST(rst), .ENABLE(enable), .O_HS(hs), .O_VS(vs), .VIDEO(video),
        .BRAM_DIN(c_din), .BRAM_ADDR(c_addr), .BRAM_WE(c_we), .WR_BANK(c_wrb), .RD_BANK(c_rdb),
        .FRAME_DONE(c_done), .LOCKED(c_lock), .LINE_COUNT(c_lc));

    typedef struct {
        int stamp;
        logic [15:0] din;
        logic [7:0]  addr;
    } wr_t;

    // Expected status after the VS edge that opens each frame
    typedef struct {
        int lines;
        bit en;
        bit drop;
        bit rst_mid;
        bit exp_done;
        bit exp_bwr;
        bit exp_brd;
        bit exp_lock;
        int exp_lc;
    } frame_t;

    wr_t qa[$];
    wr_t qb[$];
    wr_t qc[$];
    frame_t tbl [14];

    int checks;
    int errors;
    int cyc;
    int done_cnt [3];
    int done_seen [3];
    int idx_m [3];
    int lane_b;
    logic [7:0] buf_b;
    bit cap_m;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    task automatic sb_push(input int id, input logic [15:0] din, input logic [7:0] addr);
        wr_t e;
        e.stamp = cyc + 2;
        e.din   = din;
        e.addr  = addr;
        case (id)
            0:       qa.push_back(e);
            1:       qb.push_back(e);
            default: qc.push_back(e);
        endcase
    endtask

    task automatic sb_pop(input int id, input logic [15:0] din, input logic [7:0] addr);
        wr_t e;
        bit have;
        string nm;
        have = 1'b0;
        nm = (id == 0) ? "wr_a" : (id == 1) ? "wr_b" : "wr_c";
        case (id)
            0:       if (qa.size() > 0) begin e = qa.pop_front(); have = 1'b1; end
            1:       if (qb.size() > 0) begin e = qb.pop_front(); have = 1'b1; end
            default: if (qc.size() > 0) begin e = qc.pop_front(); have = 1'b1; end
        endcase
        checks++;
        if (!have) begin
            errors++;
            $display("FAIL %s unexpected write at cyc=%0d addr=%0h din=%0h, expected no write",
                     nm, cyc, addr, din);
        end else if (e.stamp != cyc || e.din !== din || e.addr !== addr) begin
            errors++;
            $display("FAIL %s actual cyc=%0d addr=%0h din=%0h, expected cyc=%0d addr=%0h din=%0h",
                     nm, cyc, addr, din, e.stamp, e.addr, e.din);
        end
    endtask

    // One clock: observe DUT outputs at the falling edge, then the caller drives inputs
    task automatic tick();
        @(negedge clk);
        cyc++;
        if (a_we) sb_pop(0, 16'(a_din), 8'(a_addr));
        if (b_we) sb_pop(1, b_din, 8'(b_addr));
        if (c_we) sb_pop(2, 16'(c_din), 8'(c_addr));
        if (a_done) done_cnt[0]++;
        if (b_done) done_cnt[1]++;
        if (c_done) done_cnt[2]++;
    endtask

    task automatic model_pixel(input logic [9:0] v, input bit bwr);
        logic [7:0] p;
        p = v[9:2];
        if (idx_m[0] < 64) sb_push(0, {8'h00, p}, 8'(idx_m[0]));
        idx_m[0]++;
        if (idx_m[2] < 16) sb_push(2, {8'h00, p}, 8'(idx_m[2]));
        idx_m[2]++;
        if (lane_b == 0) begin
            buf_b  = p;
            lane_b = 1;
        end else begin
            if (idx_m[1] < 16) sb_push(1, {p, buf_b}, 8'({bwr, 4'(idx_m[1])}));
            idx_m[1]++;
            lane_b = 0;
        end
    endtask

    task automatic reset_check(input string tag);
        chk({tag, " we"},   {a_we, b_we, c_we}, 3'b000);
        chk({tag, " din"},  {a_din, b_din, c_din}, 32'h0);
        chk({tag, " addr"}, {a_addr, b_addr, c_addr}, 15'h0);
        chk({tag, " done"}, {a_done, b_done, c_done}, 3'b000);
        chk({tag, " lock"}, {a_lock, b_lock, c_lock}, 3'b000);
        chk({tag, " lc"},   {a_lc, b_lc, c_lc}, 33'h0);
        chk({tag, " wrb"},  {a_wrb, b_wrb, c_wrb}, 3'b000);
        chk({tag, " rdb"},  {a_rdb, b_rdb, c_rdb}, 3'b010);
    endtask

    task automatic frame_check(input int fi);
        chk($sformatf("F%0d done_a", fi), done_cnt[0] - done_seen[0], tbl[fi].exp_done);
        chk($sformatf("F%0d done_b", fi), done_cnt[1] - done_seen[1], tbl[fi].exp_done);
        chk($sformatf("F%0d done_c", fi), done_cnt[2] - done_seen[2], tbl[fi].exp_done);
        for (int i = 0; i < 3; i++) done_seen[i] = done_cnt[i];
        chk($sformatf("F%0d lock", fi), {a_lock, b_lock, c_lock}, {3{tbl[fi].exp_lock}});
        chk($sformatf("F%0d lc_a", fi), a_lc, tbl[fi].exp_lc);
        chk($sformatf("F%0d lc_b", fi), b_lc, tbl[fi].exp_lc);
        chk($sformatf("F%0d lc_c", fi), c_lc, tbl[fi].exp_lc);
        chk($sformatf("F%0d wrb_b", fi), b_wrb, tbl[fi].exp_bwr);
        chk($sformatf("F%0d rdb_b", fi), b_rdb, tbl[fi].exp_brd);
        chk($sformatf("F%0d banks_ac", fi), {a_wrb, a_rdb, c_wrb, c_rdb}, 4'b0000);
    endtask

    // Line k of frame fi: 16 clocks, HS active 2 clocks, VS active 3 clocks on line 0
    task automatic drive_line(input int fi, input int k);
        for (int c = 0; c < 16; c++) begin
            tick();
            hs = (c < 2) ? 1'b0 : 1'b1;
            vs = (k == 0 && c < 3) ? 1'b0 : 1'b1;
            if (k == 0 && c == 0) begin
                enable = tbl[fi].en;
                cap_m  = tbl[fi].en;
                for (int i = 0; i < 3; i++) idx_m[i] = 0;
                lane_b = 0;
            end
            if (k == 0 && c == 4) frame_check(fi);
            if (tbl[fi].drop && k == 2 && c == 0) enable = 1'b0;
            if (tbl[fi].rst_mid && k == 2 && c == 12) begin
                rst   = 1'b1;
                cap_m = 1'b0;
                #1;
                reset_check($sformatf("F%0d midrst", fi));
            end
            if (tbl[fi].rst_mid && k == 2 && c == 14) rst = 1'b0;
            video = 10'($urandom);
            if (cap_m && k >= 1 && k <= 4 && c >= 3 && c <= 10) model_pixel(video, tbl[fi].exp_bwr);
        end
    endtask

    initial begin
        //            lines en   drop rst  done bwr  brd  lock lc
        tbl[0]  = '{6, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0};
        tbl[1]  = '{6, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 5};
        tbl[2]  = '{6, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 5};
        tbl[3]  = '{6, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 5};
        tbl[4]  = '{6, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 5};
        tbl[5]  = '{6, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 5};
        tbl[6]  = '{7, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 5};
        tbl[7]  = '{6, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 6};
        tbl[8]  = '{6, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 5};
        tbl[9]  = '{3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5};
        tbl[10] = '{6, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2};
        tbl[11] = '{6, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 5};
        tbl[12] = '{6, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3};
        tbl[13] = '{1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 5};

        checks = 0;
        errors = 0;
        cyc    = 0;
        cap_m  = 1'b0;
        lane_b = 0;
        buf_b  = 8'h00;
        for (int i = 0; i < 3; i++) begin
            done_cnt[i]  = 0;
            done_seen[i] = 0;
            idx_m[i]     = 0;
        end
        rst    = 1'b1;
        enable = 1'b0;
        hs     = 1'b1;
        vs     = 1'b1;
        video  = 10'h000;

        for (int i = 0; i < 3; i++) tick();
        #1;
        reset_check("por");
        tick();
        rst = 1'b0;
        for (int i = 0; i < 5; i++) tick();

        for (int fi = 0; fi < 14; fi++) begin
            for (int k = 0; k < tbl[fi].lines; k++) drive_line(fi, k);
        end
        for (int i = 0; i < 20; i++) tick();

        chk("drain_a", qa.size(), 0);
        chk("drain_b", qb.size(), 0);
        chk("drain_c", qc.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
